// File: rtl/pipe_stage_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_chain_if
//  Description : Bundle of the pipeline-chain signals. The master side is the
//                hazard/branch logic feeding and steering the chain. The
//                slave side is the chain itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;

  // Hazard/branch control side: issues instructions and stall/flush, observes stages
  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, stage_valid, stage_data, out_valid, out_data
  );

  // Register chain side
  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, stage_valid, stage_data, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_chain
//  Description : DEPTH-deep chain of WIDTH-bit pipeline registers with a valid
//                bit per stage. Each stage supports stall, flush and bubble
//                insertion. A saturating counter tracks retired instructions.
//                Optional build macro PIPE_ZERO_BUBBLE_EN: when defined,
//                flushed or bubbled stages also get an all-zero payload.
//                Otherwise only the valid bit is cleared.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active low
  pipe_stage_chain_if.slave  bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   retire_cnt
);

`ifdef PIPE_ZERO_BUBBLE_EN
  // Zero payload decodes as a no-op, so killed stages are scrubbed.
  localparam bit c_ZERO_BUBBLE = 1'b1;
`else
  // Killed stages keep stale payload; consumers must qualify with valid.
  localparam bit c_ZERO_BUBBLE = 1'b0;
`endif

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]       w_hold;       // stage k frozen by a stall at k or later
  logic [DEPTH-1:0]       w_valid_vec;  // registered valid bits, flattened
  logic [DEPTH*WIDTH-1:0] w_data_vec;   // registered payloads, flattened
  logic                   w_retire;
  logic [CNT_W-1:0]       r_cnt;

  // A stall in stage j freezes stage j and every stage before it.
  for (genvar k = 0; k < DEPTH; k++) begin : g_hold
    assign w_hold[k] = |bus.stall[DEPTH-1:k];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_src_valid;   // what would move into this stage
    logic [WIDTH-1:0] w_src_data;
    logic             w_bubble;      // upstream frozen while this stage advances
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    if (k == 0) begin : g_head
      assign w_src_valid = bus.in_valid;
      assign w_src_data  = bus.in_data;
      assign w_bubble    = 1'b0;
    end else begin : g_body
      assign w_src_valid = w_valid_vec[k-1];
      assign w_src_data  = w_data_vec[(k-1)*WIDTH +: WIDTH];
      assign w_bubble    = bus.stall[k-1];
    end

    // Stage register: flush beats hold, hold beats bubble, bubble beats advance.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (bus.flush[k]) begin
        r_valid <= 1'b0;
        r_data  <= c_ZERO_BUBBLE ? '0 : r_data;
      end else if (w_hold[k]) begin
        r_valid <= r_valid;
        r_data  <= r_data;
      end else if (w_bubble) begin
        r_valid <= 1'b0;
        r_data  <= c_ZERO_BUBBLE ? '0 : w_src_data;
      end else begin
        r_valid <= w_src_valid;
        r_data  <= w_src_data;
      end
    end

    assign w_valid_vec[k]                 = r_valid;
    assign w_data_vec[k*WIDTH +: WIDTH]   = r_data;
  end

  // An instruction leaves the last stage when it is valid, not held and not killed.
  assign w_retire = w_valid_vec[DEPTH-1] & ~w_hold[DEPTH-1] & ~bus.flush[DEPTH-1];

  // Saturating retire counter; a clear wins over a simultaneous retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_retire && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  // in_ready is the only combinational output; it ignores in_valid.
  assign bus.in_ready    = ~w_hold[0];
  assign bus.stage_valid = w_valid_vec;
  assign bus.stage_data  = w_data_vec;
  assign bus.out_valid   = w_valid_vec[DEPTH-1];
  assign bus.out_data    = w_data_vec[(DEPTH-1)*WIDTH +: WIDTH];
  assign retire_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of DEPTH pipeline registers, each WIDTH bits wide with a valid bit, providing per-stage stall, flush and bubble insertion for the core pipeline. It replaces the hand-written, non-stallable IF/ID, ID/EX, EX/MEM and MEM/WB register banks in the core top level. Hazard and branch logic drive it, and forwarding logic reads it. A saturating retire counter reports the number of instructions leaving the last stage.

## Interface
- WIDTH, 32, payload bits per stage (packed control plus data)
- DEPTH, 4, number of register stages (≥2)
- CNT_W, 32, retire counter width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  stage-0 input carries a real instruction
- in_data  input  WIDTH  stage-0 input payload
- in_ready  output  1  stage 0 accepts in_data this cycle
- stall  input  DEPTH  bit k holds stage k
- flush  input  DEPTH  bit k kills stage k
- cnt_clr  input  1  synchronous clear of retire_cnt
- stage_valid  output  DEPTH  valid bit of every stage
- stage_data  output  DEPTH*WIDTH  payload of every stage; stage k at [k*WIDTH +: WIDTH]
- out_valid  output  1  equals stage_valid[DEPTH-1]
- out_data  output  WIDTH  payload of stage DEPTH-1
- retire_cnt  output  CNT_W  count of retired instructions

## Operation
- hold[k] = OR of stall[DEPTH-1:k]. A stall anywhere freezes that stage and every earlier stage.
- in_ready = !hold[0]. It is combinational and does not depend on in_valid.
- Stage k update at each rising edge uses the first matching rule:
  - flush[k]: valid ← 0. Payload per Configuration.
  - hold[k]: valid and payload unchanged.
  - k==0: valid ← in_valid, payload ← in_data.
  - stall[k-1] (so hold[k-1]=1, hold[k]=0): bubble. valid ← 0, payload per Configuration.
  - otherwise: valid ← valid[k-1], payload ← payload[k-1].
- Flush beats stall in the same stage. A stall still holds earlier stages when its own stage is flushed.
- A retire happens on a cycle with valid[DEPTH-1]=1, hold[DEPTH-1]=0 and flush[DEPTH-1]=0.
- retire_cnt:
  - cnt_clr → 0. cnt_clr has priority over a simultaneous retire.
  - Otherwise +1 on each retire, saturating at all-ones with no wrap.
- Payload is never inspected. Width rules apply only to the counter.

## Timing
- Reset (rst low, asynchronous): all valid bits 0, all payload 0, retire_cnt 0.
- Outputs while rst is low: in_ready follows stall; out_valid=0; stage_valid=0.
- Reset deassertion is sampled synchronously. The first update happens on the first rising edge with rst high.
- Latency with no stalls is DEPTH cycles from in_data to out_data. Throughput is one per cycle.
- stall and flush are sampled on the edge and affect state only at that edge. No combinational path exists from stall or flush to stage_* or out_*.
- in_ready is the only combinational output (stall → in_ready).
- Reset asserted mid-stall or mid-flush clears everything immediately. No held state survives reset.
- retire_cnt reflects a retire one cycle after the retiring edge, that is, registered.

## Configuration
- PIPE_ZERO_BUBBLE_EN defined:
  - Payload is forced to all-zero whenever a stage is flushed or receives a bubble.
  - Zero payload decodes as a no-op control word, so downstream logic may ignore valid.
- PIPE_ZERO_BUBBLE_EN undefined:
  - Flush and bubble clear only the valid bit. Payload keeps its previous value (flush) or takes stage k-1's payload (bubble).
  - Downstream logic must qualify everything with stage_valid.

## Test plan
- Streaming: DEPTH=4, in_valid=1, in_data=1,2,3,… with no stall → out_data=1 at cycle 4, then 2,3,… every cycle; retire_cnt=N after N retires.
- Stall stage 1 for 2 cycles with stages full:
  - in_ready=0, and stages 0–1 are held.
  - Stage 2 receives 2 bubbles (valid=0; payload 0 with PIPE_ZERO_BUBBLE_EN).
  - No data is lost or duplicated.
- Flush: flush=4'b0011 with stall=4'b0001 in the same cycle → stages 0 and 1 become invalid, and stage 0 does not load in_data.
- Saturation: CNT_W=4, retire 20 instructions → retire_cnt=15. cnt_clr together with a retire → 0.
- Reset: assert rst low mid-stream with stall active → all stage_valid=0, out_valid=0 and retire_cnt=0 immediately, without waiting for a clock edge. Streaming resumes on the first edge after release.
